apb_master_arb: RTL

- Round-robin APB master that lets NUM_REQ requesters share one APB bus, such as the PWM register port.
- Each requester issues single read/write commands over a valid/ready interface.
- The block serialises the commands into standard APB SETUP/ACCESS transfers, honours PREADY wait states and returns PRDATA/PSLVERR to the granted requester.
- It sits between the CPU/DMA-side command sources and the peripheral APB slaves.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/apb_master_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the round-robin APB master (apb_master_arb).
package apb_arb_pkg;

    localparam int APB_ADDR_W_DEF = 32;
    localparam int APB_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_W_DEF-1:0] addr;
        logic [APB_DATA_W_DEF-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan from the slot after last_grant; the first hit wins and masks all later ones.
    always_comb begin
        grant  = {NUM_REQ{1'b0}};
        idx    = {IDX_W{1'b0}};
        any    = 1'b0;
        cand_s = {IDX_W{1'b0}};
        hit_s  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s        = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            hit_s         = !any && req[cand_s];
            grant[cand_s] = hit_s;
            idx           = hit_s ? cand_s : idx;
            any           = any | hit_s;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master: NUM_REQ valid/ready command ports serialised onto one APB bus.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC wait cycles.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = APB_ADDR_W_DEF,
    parameter int DATA_W      = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETUP  = ST_SETUP;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   grant_idx_r;
    cmd_t               cmd_r;
    logic               psel_r;
    logic               penable_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               rsp_slverr_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               any_s;
    logic               to_hit_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .idx        (win_idx_s),
        .any        (any_s)
    );

    assign req_ready = (state_r == S_IDLE) ? grant_s : {NUM_REQ{1'b0}};

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_r;

    // Counts ACCESS cycles; a low pready on the limit cycle aborts, a high one completes normally.
    assign to_hit_s = (state_r == S_ACCESS) && !pready && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    // ACCESS-phase cycle counter, cleared whenever the FSM is elsewhere.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == S_ACCESS) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Transfer FSM: accept in IDLE, one SETUP cycle, ACCESS until pready (or abort).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r      <= S_IDLE;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            grant_idx_r  <= {IDX_W{1'b0}};
            cmd_r        <= '0;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            rsp_valid_r  <= {NUM_REQ{1'b0}};
            rsp_rdata_r  <= {DATA_W{1'b0}};
            rsp_slverr_r <= 1'b0;
        end else begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (any_s) begin
                        cmd_r.write  <= req_write[win_idx_s];
                        cmd_r.addr   <= req_addr[win_idx_s*ADDR_W +: ADDR_W];
                        cmd_r.wdata  <= req_wdata[win_idx_s*DATA_W +: DATA_W];
                        grant_idx_r  <= win_idx_s;
                        last_grant_r <= win_idx_s;
                        psel_r       <= 1'b1;
                        state_r      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready || to_hit_s) begin
                        psel_r                   <= 1'b0;
                        penable_r                <= 1'b0;
                        cmd_r                    <= '0;
                        rsp_valid_r[grant_idx_r] <= 1'b1;
                        rsp_rdata_r              <= (pready && !cmd_r.write) ? prdata : {DATA_W{1'b0}};
                        rsp_slverr_r             <= pready ? pslverr : 1'b1;
                        state_r                  <= S_IDLE;
                    end
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    assign paddr      = cmd_r.addr;
    assign pwrite     = cmd_r.write;
    assign pwdata     = cmd_r.wdata;
    assign psel       = psel_r;
    assign penable    = penable_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_slverr = rsp_slverr_r;

endmodule
